// File: rtl/fpu_ss_result_fifo.sv
// fpu_ss_result_fifo
//   Result-side decoupling FIFO between fpu_ss.x_result_o and the core's
//   CV-X-IF result port. It buffers up to DEPTH result packets in order, so
//   a core that stalls x_result_ready does not immediately stall the FPU.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous clear of all entries (wins over push/pop)
//   in_valid_i   result valid from fpu_ss
//   in_ready_o   FIFO can accept a result
//   in_data_i    result packet from fpu_ss
//   out_valid_o  result valid toward the core
//   out_ready_i  core accepts the head result
//   out_data_o   head result packet
//   usage_o      number of stored entries, 0..DEPTH
//   full_o       usage_o == DEPTH
//   empty_o      usage_o == 0
//
// Parameters
//   DEPTH         number of entries, 1..16 (any value, not only powers of two)
//   FALL_THROUGH  1: an empty FIFO forwards the input combinationally
//                 0: at least one cycle from push to out_valid_o

`timescale 1ns/1ps

package fpu_ss_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
  } x_result_t;

endpackage

module fpu_ss_result_fifo
  import fpu_ss_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  x_result_t                    in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output x_result_t                    out_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UW = $clog2(DEPTH + 1);

  x_result_t         mem [DEPTH];
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     wptr;
  logic [UW-1:0]     usage;

  logic              empty;
  logic              full;
  logic              bypass;
  logic              push;
  logic              pop;

  assign empty = (usage == '0);
  assign full  = (usage == UW'(DEPTH));

  // A bypass hands the packet straight to the core; storage is untouched.
  assign bypass = FALL_THROUGH && empty && in_valid_i && out_ready_i && !flush_i;

  // Ready depends only on state and flush: no combinational path from
  // out_ready_i, so a full FIFO refuses pushes even in a popping cycle.
  assign in_ready_o = !full && !flush_i;

  always_comb begin
    out_valid_o = !empty && !flush_i;
    out_data_o  = mem[rptr];
    if (FALL_THROUGH && empty) begin
      out_valid_o = in_valid_i && !flush_i;
      out_data_o  = in_data_i;
    end
  end

  // Storage-level handshakes; both are suppressed by flush through the
  // ready/valid terms above.
  assign push = in_valid_i && in_ready_o && !bypass;
  assign pop  = out_valid_o && out_ready_i && !empty;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    // Explicit wrap so that non-power-of-two depths stay in range.
    if (ptr == AW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + AW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      usage <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      usage <= '0;
    end else begin
      if (push) begin
        wptr <= next_ptr(wptr);
      end
      if (pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({push, pop})
        2'b10:   usage <= usage + UW'(1);
        2'b01:   usage <= usage - UW'(1);
        default: usage <= usage;
      endcase
    end
  end

  // Flush leaves the contents in place; only the pointers matter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= in_data_i;
    end
  end

  assign usage_o = usage;
  assign full_o  = full;
  assign empty_o = empty;

`ifndef SYNTHESIS
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && empty));
  a_usage_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    usage <= UW'(DEPTH));
  // A producer held off by a full FIFO must keep its packet stable.
  a_in_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_valid_i && !in_ready_o && !flush_i) |=> (!in_valid_i || $stable(in_data_i)));
`endif

endmodule

// File: doc/fpu_ss_result_fifo.md
Name: fpu_ss_result_fifo

Overview:
Result-side decoupling FIFO placed directly downstream of fpu_ss on the CV-X-IF result interface. It captures x_result_t packets produced by fpu_ss and presents them, in order, to the core's result port. A core that stalls x_result_ready therefore no longer back-pressures the FPU pipeline until DEPTH results are pending. Used inside the fpu_ss_wrapper level, between fpu_ss.x_result_o and the wrapper's x_result_o.

Parameters:
DEPTH, 4, number of result entries; legal range 1..16, not required to be a power of two.
FALL_THROUGH, 0, 1 = when empty, input is forwarded combinationally to the output in the same cycle; 0 = minimum 1-cycle latency.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of all entries
in_valid_i  input  1  result valid from fpu_ss (x_result_valid_o)
in_ready_o  output  1  FIFO can accept (drives fpu_ss x_result_ready_i)
in_data_i  input  $bits(fpu_ss_pkg::x_result_t)  result packet from fpu_ss
out_valid_o  output  1  result valid toward the core
out_ready_i  input  1  core accepts result
out_data_o  output  $bits(fpu_ss_pkg::x_result_t)  head result packet
usage_o  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH
full_o  output  1  usage_o == DEPTH
empty_o  output  1  usage_o == 0

Behaviour:
- Reset (rst_ni low, asynchronous): read/write pointers = 0, usage_o = 0, all storage = 0. Outputs: out_valid_o = 0, out_data_o = 0, in_ready_o = 1, full_o = 0, empty_o = 1. Reset asserted mid-transfer discards all entries; no handshake completes in that cycle.
- Push: in_valid_i && in_ready_o at a rising edge; data is written at wptr, and wptr advances.
- Pop: out_valid_o && out_ready_i at a rising edge; rptr advances.
- Pointer wrap: each pointer goes from DEPTH-1 to 0. This must be explicit for non-power-of-two DEPTH.
- in_ready_o = !full_o && !flush_i.
- out_data_o = mem[rptr] when not empty.
- out_valid_o = !empty_o && !flush_i, with the fall-through exception below.
- FALL_THROUGH=1 and empty:
  - out_valid_o = in_valid_i && !flush_i, and out_data_o = in_data_i.
  - If out_ready_i is high in that cycle, the packet is consumed without being written and usage stays 0.
  - Otherwise the packet is written and usage becomes 1.
- FALL_THROUGH=0 and empty: out_valid_o = 0. A pushed packet appears on out_data_o with out_valid_o = 1 in the next cycle (latency 1).
- Simultaneous push and pop while not empty: both pointers advance, usage unchanged. This is legal when usage_o == DEPTH only if... in_ready_o is low when full, so no push occurs when full even if a pop happens that cycle (no combinational ready-through path).
- Usage update:
  - +1 on push only, -1 on pop only.
  - Unchanged on push+pop, and on a fall-through bypass.
- Ordering: strict FIFO. Packet fields (id, rd, data, we, exc) are never modified.
- out_data_o must be held stable while out_valid_o && !out_ready_i.
- flush_i:
  - Takes priority over push and pop; no handshake completes in the flush cycle.
  - Next cycle: pointers = 0, usage_o = 0, empty_o = 1.
  - Storage contents need not be cleared.
- Assertions (simulation only):
  - no push when full;
  - no pop when empty;
  - usage_o <= DEPTH;
  - in_data_i stable while in_valid_i && !in_ready_o.

Test Plan:
- Reset then idle, DEPTH=4 -> in_ready_o=1, out_valid_o=0, usage_o=0, empty_o=1 and full_o=0 for 10 cycles.
- FALL_THROUGH=0, out_ready_i=0, push ids 1,2,3,4 on consecutive cycles -> full_o=1 and in_ready_o=0 after the 4th push. A 5th valid is held with no push. Set out_ready_i=1 -> ids popped as 1,2,3,4, then the held 5, one per cycle.
- FALL_THROUGH=0, single push of id 7 with data 0x3F800000 at cycle t -> out_valid_o=1 with id 7 at cycle t+1, not at cycle t.
- FALL_THROUGH=1, empty, in_valid_i=1 with out_ready_i=1 (id 9) -> out_valid_o=1 and id 9 in the same cycle; usage_o stays 0.
- DEPTH=3, continuous push+pop for 20 cycles with ids 0..19 -> pointers wrap 2->0 correctly, output order is 0..19, usage_o constant.
- Usage=3 with flush_i=1 while in_valid_i=1 and out_ready_i=1 -> no handshake that cycle; next cycle usage_o=0, out_valid_o=0. Asserting rst_ni=0 mid-stream clears the FIFO asynchronously before the next clock edge.
